c_bus_wb_arbiter: RTL and testbench
===================================

Name: c_bus_wb_arbiter

Overview:
Write-back arbiter and sequencer for the C bus of the micro datapath. Shares the C bus and the register-file write port between two requesters: ALU results (single-cycle) and memory load responses (variable latency). Drives the C-bus mux select plus register-file write enable and address. Tracks one outstanding load with a WAW hazard check and a timeout.

Parameters:
REG_ADDR_W, 6, register-file address width.
TIMEOUT_CYC, 16, maximum cycles a load may stay pending before abort (>=2).
CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
CLOCK_50  in  1  system clock, rising edge.
RESET_InHigh  in  1  asynchronous reset, active-high.
LOAD_ISSUE  in  1  datapath issues a load this cycle.
LOAD_DEST  in  REG_ADDR_W  destination register of the issued load.
LOAD_BUSY  out  1  load slot occupied; a LOAD_ISSUE in this cycle is not accepted.
MEM_VALID  in  1  memory response data is valid on the memory input of the C-bus mux.
MEM_READY  out  1  memory response consumed this cycle.
ALU_VALID  in  1  ALU result valid on the ALU input of the C-bus mux.
ALU_DEST  in  REG_ADDR_W  destination register of the ALU result.
ALU_READY  out  1  ALU result consumed this cycle.
C_SELECT  out  1  mux select; 1 selects the memory bus, 0 selects the ALU bus.
RF_WR_EN  out  1  register-file write strobe; the write occurs at the clock edge.
RF_WR_ADDR  out  REG_ADDR_W  register-file write address.
LOAD_ERR  out  1  sticky flag set on load timeout.
ERR_CLR  in  1  synchronous clear of LOAD_ERR.

Behaviour:
- FSM states: IDLE and LOAD_PEND. Reset state is IDLE; pend_dest and timeout counter reset to 0; LOAD_ERR resets to 0.
- Handshake outputs are combinational from the current state and inputs. RF writes happen on the same clock edge as the handshake (zero added latency).
- While RESET_InHigh is asserted, all outputs are 0.
- IDLE:
  - LOAD_BUSY=0, MEM_READY=0. MEM_VALID is ignored (stray responses are dropped).
  - ALU_READY=1. When ALU_VALID=1: RF_WR_EN=1, C_SELECT=0, RF_WR_ADDR=ALU_DEST.
  - LOAD_ISSUE=1: latch LOAD_DEST into pend_dest, clear the counter, go to LOAD_PEND next cycle.
  - An ALU write and a LOAD_ISSUE in the same cycle are both accepted.
- LOAD_PEND:
  - LOAD_BUSY=1; LOAD_ISSUE is ignored.
  - MEM_VALID=1 (memory has priority): MEM_READY=1, RF_WR_EN=1, C_SELECT=1, RF_WR_ADDR=pend_dest, ALU_READY=0. Go to IDLE next cycle.
  - MEM_VALID=0: ALU_READY = (ALU_DEST != pend_dest). A WAW hazard stalls the ALU. An accepted ALU write behaves as in IDLE.
  - Counter increments each LOAD_PEND cycle without MEM_VALID. At counter==TIMEOUT_CYC-1 with MEM_VALID=0: set LOAD_ERR, go to IDLE, no RF write.
  - MEM_VALID arriving in the timeout cycle wins: it is consumed normally and no error is raised.
- When no write occurs: RF_WR_EN=0, C_SELECT=0, RF_WR_ADDR=0.
- LOAD_ERR: set has priority over ERR_CLR in the same cycle; otherwise ERR_CLR clears it.
- Reset mid-load: the pending load is discarded; a later MEM_VALID in IDLE is ignored.

Optional Feature:
Macro CBUS_WB_STATS_EN.
- Defined: adds outputs STAT_MEM_WR, STAT_ALU_WR and STAT_ALU_STALL, each CNT_W wide.
  - STAT_MEM_WR counts memory writes; STAT_ALU_WR counts ALU writes; STAT_ALU_STALL counts cycles with ALU_VALID=1 and ALU_READY=0.
  - All counters reset to 0 and saturate at the maximum value.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cbus_wb_pkg:
  - FSM state encoding (IDLE=1'b0, LOAD_PEND=1'b1).
  - Select constants C_SEL_ALU=0 and C_SEL_MEM=1.
  - Default REG_ADDR_W.
- Sub-module wb_sat_counter (CNT_W-wide saturating counter with increment enable), instantiated three times under the macro.

Test Plan:
1. Reset, then ALU_VALID=1, ALU_DEST=5 in IDLE -> ALU_READY=1, RF_WR_EN=1, C_SELECT=0, RF_WR_ADDR=5 in the same cycle.
2. LOAD_ISSUE with LOAD_DEST=9, MEM_VALID 3 cycles later -> LOAD_BUSY=1 for 3 cycles; on the response cycle MEM_READY=1, C_SELECT=1, RF_WR_ADDR=9; LOAD_BUSY=0 in the next cycle.
3. Load pending to reg 9; ALU_VALID with ALU_DEST=9, then ALU_DEST=4 -> dest 9 stalls (ALU_READY=0), dest 4 is written; the dest-9 ALU write happens only after the memory write to 9.
4. Load pending plus MEM_VALID and ALU_VALID (dest 4) in the same cycle -> memory write, ALU_READY=0; the ALU write to 4 follows in the next cycle.
5. LOAD_ISSUE with no MEM_VALID for TIMEOUT_CYC=16 cycles -> LOAD_ERR=1, state IDLE, no write; a subsequent MEM_VALID is ignored; ERR_CLR clears the flag.
6. RESET_InHigh asserted mid-load -> all outputs 0 immediately; after release LOAD_BUSY=0 and MEM_VALID is ignored. With CBUS_WB_STATS_EN defined, scenarios 1–4 yield STAT_MEM_WR=2, STAT_ALU_WR=4, STAT_ALU_STALL=2.

Source files
------------

// File: rtl/c_bus_wb_arbiter_pkg.sv
// rtl/c_bus_wb_arbiter_pkg.sv - shared constants for the C-bus write-back arbiter
package cbus_wb_pkg;

    localparam int REG_ADDR_W_DEF = 6;

    typedef logic [0:0] wb_state_t;

    localparam wb_state_t IDLE      = 1'b0;
    localparam wb_state_t LOAD_PEND = 1'b1;

    localparam logic C_SEL_ALU = 1'b0;
    localparam logic C_SEL_MEM = 1'b1;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/c_bus_wb_arbiter_if.sv
// rtl/c_bus_wb_arbiter_if.sv - datapath/memory/register-file signals of the C-bus write-back arbiter
interface c_bus_wb_arbiter_if
    import cbus_wb_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
    logic                  LOAD_ISSUE;
    logic [REG_ADDR_W-1:0] LOAD_DEST;
    logic                  LOAD_BUSY;
    logic                  MEM_VALID;
    logic                  MEM_READY;
    logic                  ALU_VALID;
    logic [REG_ADDR_W-1:0] ALU_DEST;
    logic                  ALU_READY;
    logic                  C_SELECT;
    logic                  RF_WR_EN;
    logic [REG_ADDR_W-1:0] RF_WR_ADDR;
    logic                  LOAD_ERR;
    logic                  ERR_CLR;

    // Datapath / memory side
    modport master (
        output LOAD_ISSUE, LOAD_DEST, MEM_VALID, ALU_VALID, ALU_DEST, ERR_CLR,
        input  LOAD_BUSY, MEM_READY, ALU_READY, C_SELECT, RF_WR_EN, RF_WR_ADDR, LOAD_ERR
    );

    // Arbiter side
    modport slave (
        input  LOAD_ISSUE, LOAD_DEST, MEM_VALID, ALU_VALID, ALU_DEST, ERR_CLR,
        output LOAD_BUSY, MEM_READY, ALU_READY, C_SELECT, RF_WR_EN, RF_WR_ADDR, LOAD_ERR
    );

endinterface

// File: rtl/c_bus_wb_arbiter_sat_counter.sv
// rtl/c_bus_wb_arbiter_sat_counter.sv - saturating event counter with increment enable
module wb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/c_bus_wb_arbiter.sv
// rtl/c_bus_wb_arbiter.sv - C-bus write-back arbiter: ALU vs. one outstanding load, WAW stall, load timeout
// Optional statistics counters are built when CBUS_WB_STATS_EN is defined.
module c_bus_wb_arbiter
    import cbus_wb_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 16
`ifdef CBUS_WB_STATS_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InHigh,
    c_bus_wb_arbiter_if.slave    bus
`ifdef CBUS_WB_STATS_EN
    ,
    output logic [CNT_W-1:0]     STAT_MEM_WR,
    output logic [CNT_W-1:0]     STAT_ALU_WR,
    output logic [CNT_W-1:0]     STAT_ALU_STALL
`endif
);

    localparam int              TO_W   = cnt_width(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    wb_state_t             state;
    logic [REG_ADDR_W-1:0] pend_dest;
    logic [TO_W-1:0]       to_cnt;
    logic                  load_err;

    logic run;
    logic pending;
    logic mem_wr;
    logic alu_ready;
    logic alu_wr;
    logic alu_stall;
    logic timeout;

    // Outputs are forced low while reset is held, independent of state.
    always_comb begin
        run       = ~RESET_InHigh;
        pending   = (state == LOAD_PEND);
        mem_wr    = run & pending & bus.MEM_VALID;
        alu_ready = run & (~pending | (~bus.MEM_VALID & (bus.ALU_DEST != pend_dest)));
        alu_wr    = alu_ready & bus.ALU_VALID;
        alu_stall = run & bus.ALU_VALID & ~alu_ready;
        timeout   = pending & ~bus.MEM_VALID & (to_cnt == TO_MAX);
    end

    always_comb begin
        bus.LOAD_BUSY  = run & pending;
        bus.MEM_READY  = mem_wr;
        bus.ALU_READY  = alu_ready;
        bus.RF_WR_EN   = mem_wr | alu_wr;
        bus.C_SELECT   = mem_wr ? C_SEL_MEM : C_SEL_ALU;
        bus.RF_WR_ADDR = '0;
        if (mem_wr) begin
            bus.RF_WR_ADDR = pend_dest;
        end else if (alu_wr) begin
            bus.RF_WR_ADDR = bus.ALU_DEST;
        end
        bus.LOAD_ERR   = run & load_err;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state     <= IDLE;
            pend_dest <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.LOAD_ISSUE) begin
                        state     <= LOAD_PEND;
                        pend_dest <= bus.LOAD_DEST;
                        to_cnt    <= '0;
                    end
                end
                LOAD_PEND: begin
                    // A response in the timeout cycle still completes the load.
                    if (bus.MEM_VALID || timeout) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            load_err <= 1'b0;
        end else if (timeout) begin
            load_err <= 1'b1;
        end else if (bus.ERR_CLR) begin
            load_err <= 1'b0;
        end
    end

`ifdef CBUS_WB_STATS_EN
    wb_sat_counter #(.CNT_W(CNT_W)) u_stat_mem_wr (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .inc   (mem_wr),
        .count (STAT_MEM_WR)
    );

    wb_sat_counter #(.CNT_W(CNT_W)) u_stat_alu_wr (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .inc   (alu_wr),
        .count (STAT_ALU_WR)
    );

    wb_sat_counter #(.CNT_W(CNT_W)) u_stat_alu_stall (
        .clk   (CLOCK_50),
        .rst   (RESET_InHigh),
        .inc   (alu_stall),
        .count (STAT_ALU_STALL)
    );
`endif

endmodule

// File: tb/tb_c_bus_wb_arbiter.sv
// tb/tb_c_bus_wb_arbiter.sv - directed self-checking bench for c_bus_wb_arbiter
module tb_c_bus_wb_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    c_bus_wb_arbiter_if #(.REG_ADDR_W(6)) bus ();

`ifdef CBUS_WB_STATS_EN
    logic [15:0] stat_mem_wr;
    logic [15:0] stat_alu_wr;
    logic [15:0] stat_alu_stall;
`endif

    c_bus_wb_arbiter #(
        .REG_ADDR_W  (6),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLOCK_50      (clk),
        .RESET_InHigh  (rst),
        .bus           (bus.slave)
`ifdef CBUS_WB_STATS_EN
        ,
        .STAT_MEM_WR   (stat_mem_wr),
        .STAT_ALU_WR   (stat_alu_wr),
        .STAT_ALU_STALL(stat_alu_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.LOAD_ISSUE = 1'b0;
        bus.LOAD_DEST  = '0;
        bus.MEM_VALID  = 1'b0;
        bus.ALU_VALID  = 1'b0;
        bus.ALU_DEST   = '0;
        bus.ERR_CLR    = 1'b0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();

        @(negedge clk);
        settle();
        check("rst_busy",   32'(bus.LOAD_BUSY),  0);
        check("rst_wr_en",  32'(bus.RF_WR_EN),   0);
        check("rst_err",    32'(bus.LOAD_ERR),   0);
        check("rst_ready",  32'(bus.ALU_READY),  0);

        // Scenario 1: ALU write in IDLE
        next_cycle();
        rst = 1'b0;
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd5;
        settle();
        check("s1_alu_ready", 32'(bus.ALU_READY),  1);
        check("s1_wr_en",     32'(bus.RF_WR_EN),   1);
        check("s1_csel",      32'(bus.C_SELECT),   0);
        check("s1_addr",      32'(bus.RF_WR_ADDR), 5);

        // Scenario 2: load to 9 answered three cycles later
        next_cycle();
        bus.LOAD_ISSUE = 1'b1;
        bus.LOAD_DEST  = 6'd9;
        settle();
        check("s2_issue_busy", 32'(bus.LOAD_BUSY), 0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            settle();
            check("s2_wait_busy",  32'(bus.LOAD_BUSY),  1);
            check("s2_wait_wr_en", 32'(bus.RF_WR_EN),   0);
            check("s2_wait_addr",  32'(bus.RF_WR_ADDR), 0);
        end
        next_cycle();
        bus.MEM_VALID = 1'b1;
        settle();
        check("s2_resp_busy",  32'(bus.LOAD_BUSY),  1);
        check("s2_mem_ready",  32'(bus.MEM_READY),  1);
        check("s2_csel",       32'(bus.C_SELECT),   1);
        check("s2_addr",       32'(bus.RF_WR_ADDR), 9);
        check("s2_wr_en",      32'(bus.RF_WR_EN),   1);
        next_cycle();
        settle();
        check("s2_after_busy", 32'(bus.LOAD_BUSY),  0);
        check("s2_after_mrdy", 32'(bus.MEM_READY),  0);

        // Scenarios 3 and 4: WAW stall, then memory beats ALU
        bus.LOAD_ISSUE = 1'b1;
        bus.LOAD_DEST  = 6'd9;
        next_cycle();
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd9;
        settle();
        check("s3_waw_ready", 32'(bus.ALU_READY), 0);
        check("s3_waw_wr_en", 32'(bus.RF_WR_EN),  0);
        check("s3_waw_busy",  32'(bus.LOAD_BUSY), 1);
        next_cycle();
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd4;
        settle();
        check("s3_d4_ready",  32'(bus.ALU_READY),  1);
        check("s3_d4_wr_en",  32'(bus.RF_WR_EN),   1);
        check("s3_d4_addr",   32'(bus.RF_WR_ADDR), 4);
        check("s3_d4_csel",   32'(bus.C_SELECT),   0);
        next_cycle();
        bus.MEM_VALID = 1'b1;
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd4;
        settle();
        check("s4_mem_ready", 32'(bus.MEM_READY),  1);
        check("s4_alu_ready", 32'(bus.ALU_READY),  0);
        check("s4_addr",      32'(bus.RF_WR_ADDR), 9);
        check("s4_csel",      32'(bus.C_SELECT),   1);
        next_cycle();
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd4;
        settle();
        check("s4_alu_ready2", 32'(bus.ALU_READY),  1);
        check("s4_addr2",      32'(bus.RF_WR_ADDR), 4);
        check("s4_busy2",      32'(bus.LOAD_BUSY),  0);
        next_cycle();
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd9;
        settle();
        check("s3_d9_ready",  32'(bus.ALU_READY),  1);
        check("s3_d9_wr_en",  32'(bus.RF_WR_EN),   1);
        check("s3_d9_addr",   32'(bus.RF_WR_ADDR), 9);
        next_cycle();
        settle();
`ifdef CBUS_WB_STATS_EN
        check("stat_mem_wr",    32'(stat_mem_wr),    2);
        check("stat_alu_wr",    32'(stat_alu_wr),    4);
        check("stat_alu_stall", 32'(stat_alu_stall), 2);
`endif

        // Response arriving in the timeout cycle still wins
        bus.LOAD_ISSUE = 1'b1;
        bus.LOAD_DEST  = 6'd3;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
        end
        next_cycle();
        bus.MEM_VALID = 1'b1;
        settle();
        check("to_edge_mrdy", 32'(bus.MEM_READY),  1);
        check("to_edge_addr", 32'(bus.RF_WR_ADDR), 3);
        next_cycle();
        settle();
        check("to_edge_err",  32'(bus.LOAD_ERR),   0);
        check("to_edge_busy", 32'(bus.LOAD_BUSY),  0);

        // Scenario 5: timeout; ERR_CLR in the timeout cycle loses to the set
        bus.LOAD_ISSUE = 1'b1;
        bus.LOAD_DEST  = 6'd7;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            if (i == 15) bus.ERR_CLR = 1'b1;
            settle();
            check("s5_wait_busy",  32'(bus.LOAD_BUSY), 1);
            check("s5_wait_wr_en", 32'(bus.RF_WR_EN),  0);
            check("s5_wait_err",   32'(bus.LOAD_ERR),  0);
        end
        next_cycle();
        bus.MEM_VALID = 1'b1;
        settle();
        check("s5_err_set",     32'(bus.LOAD_ERR),  1);
        check("s5_idle_busy",   32'(bus.LOAD_BUSY), 0);
        check("s5_stray_mrdy",  32'(bus.MEM_READY), 0);
        check("s5_stray_wr_en", 32'(bus.RF_WR_EN),  0);
        next_cycle();
        bus.ERR_CLR = 1'b1;
        settle();
        check("s5_err_hold", 32'(bus.LOAD_ERR), 1);
        next_cycle();
        settle();
        check("s5_err_clr",  32'(bus.LOAD_ERR), 0);

        // Scenario 6: reset in the middle of a load
        bus.LOAD_ISSUE = 1'b1;
        bus.LOAD_DEST  = 6'd2;
        next_cycle();
        bus.ALU_VALID = 1'b1;
        bus.ALU_DEST  = 6'd5;
        settle();
        check("s6_pre_busy", 32'(bus.LOAD_BUSY), 1);
        settle();
        rst = 1'b1;
        settle();
        check("s6_rst_busy",  32'(bus.LOAD_BUSY),  0);
        check("s6_rst_ready", 32'(bus.ALU_READY),  0);
        check("s6_rst_wr_en", 32'(bus.RF_WR_EN),   0);
        check("s6_rst_addr",  32'(bus.RF_WR_ADDR), 0);
        check("s6_rst_mrdy",  32'(bus.MEM_READY),  0);
        next_cycle();
        rst = 1'b0;
        bus.MEM_VALID = 1'b1;
        settle();
        check("s6_post_busy",  32'(bus.LOAD_BUSY), 0);
        check("s6_post_mrdy",  32'(bus.MEM_READY), 0);
        check("s6_post_wr_en", 32'(bus.RF_WR_EN),  0);
        next_cycle();
        settle();
        check("s6_post2_busy", 32'(bus.LOAD_BUSY), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
